// File: rtl/vme_buf_ctrl_pkg.sv
// rtl/vme_buf_ctrl_pkg.sv - shared types and constants for the VME buffer sequencer
//
// Purpose : FSM state encoding, transceiver direction constants and a small
//           elaboration-time helper used by vme_buf_ctrl.
// Ports   : none (package)

package vme_buf_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    TURN_OFF,
    TURN_ON,
    DRIVE,
    ACK,
    ERR,
    RELEASE
  } t_buf_state;

  localparam logic c_DIR_BUS2FPGA = 1'b0;
  localparam logic c_DIR_FPGA2BUS = 1'b1;

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vme_dly_cnt.sv
// rtl/vme_dly_cnt.sv - loadable saturating down-counter with zero flag
//
// Purpose : Times dead-time, settle and watchdog intervals. Loading N-1 on
//           state entry makes zero_o assert in the N-th cycle of that state.
// Ports   :
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset (count -> 0)
//   load_i      in   load load_val_i this edge
//   load_val_i  in   value to load
//   zero_o      out  count is zero

module vme_dly_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/vme_buf_ctrl.sv
// rtl/vme_buf_ctrl.sv - VME transceiver direction/OE and DTACK/BERR sequencer
//
// Purpose : Reverses the VME data transceivers with dead time around each
//           direction change, acknowledges with DTACK or BERR, then restores
//           bus-to-FPGA listening. All outputs are registered.
// Option  : `define VME_BUF_TIMEOUT_EN adds a watchdog that forces RELEASE
//           after g_TIMEOUT cycles outside IDLE and pulses timeout_o.
// Ports   :
//   clk_i, rst_i          clock, synchronous active-high reset
//   as_n_i, ds_n_i[1:0]   synchronised VME AS_n / DS_n
//   xfer_i, is_read_i     transfer request pulse and its direction
//   rdy_i, err_i          core ready pulse and error qualifier
//   data_drive_o          FPGA-side data tri-state enable
//   data_sample_o         latch write data pulse
//   done_o                back-to-IDLE pulse
//   addr_dir_o/oe_n_o     address transceiver controls
//   data_dir_o/oe_n_o     data transceiver controls
//   dtack_oe_o, dtack_n_o DTACK driver controls
//   berr_o                BERR toward the buffer
//   timeout_o             watchdog pulse

module vme_buf_ctrl
  import vme_buf_ctrl_pkg::*;
#(
  parameter int g_DEAD    = 2,
  parameter int g_SETTLE  = 3,
  parameter int g_TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       as_n_i,
  input  logic [1:0] ds_n_i,
  input  logic       xfer_i,
  input  logic       is_read_i,
  input  logic       rdy_i,
  input  logic       err_i,
  output logic       data_drive_o,
  output logic       data_sample_o,
  output logic       done_o,
  output logic       addr_dir_o,
  output logic       addr_oe_n_o,
  output logic       data_dir_o,
  output logic       data_oe_n_o,
  output logic       dtack_oe_o,
  output logic       dtack_n_o,
  output logic       berr_o,
  output logic       timeout_o
);

  // RELEASE needs two cycles so data_drive_o drops one cycle before the
  // direction flips back while OE stays off.
  localparam int c_REL = f_max(g_DEAD, 2);
  localparam int c_DW  = $clog2(f_max(c_REL, g_SETTLE) + 1);

  if (g_DEAD < 1) begin : g_chk_dead
    $error("g_DEAD must be >= 1");
  end
  if (g_SETTLE < 1) begin : g_chk_settle
    $error("g_SETTLE must be >= 1");
  end
  if (g_TIMEOUT < 2) begin : g_chk_timeout
    $error("g_TIMEOUT must be >= 2");
  end

  t_buf_state state, state_nx;
  logic       is_read_q;
  logic       abort;
  logic       dly_load, dly_zero;
  logic [c_DW-1:0] dly_val;
  logic       tmo_fire;

  logic drive_nx, sample_nx, done_nx, addr_oe_n_nx, dir_nx, oe_n_nx;
  logic dtack_oe_nx, dtack_n_nx, berr_nx;
  logic first_rel;

  // Master walked away: AS and both DS released.
  assign abort = as_n_i && (ds_n_i == 2'b11);

  // ---------------------------------------------------------------- delays
  assign dly_load = (state_nx != state);

  always_comb begin
    dly_val = '0;
    case (state_nx)
      TURN_OFF, TURN_ON: dly_val = c_DW'(g_DEAD - 1);
      DRIVE:             dly_val = c_DW'(g_SETTLE - 1);
      RELEASE:           dly_val = c_DW'(c_REL - 1);
      default:           dly_val = '0;
    endcase
  end

  vme_dly_cnt #(.W(c_DW)) u_dly (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .zero_o     (dly_zero)
  );

`ifdef VME_BUF_TIMEOUT_EN
  localparam int c_TW = $clog2(g_TIMEOUT + 1);
  logic tmo_zero;

  // Held loaded while IDLE; counts from the first non-IDLE cycle. Loading
  // g_TIMEOUT-2 makes the (registered) pulse land g_TIMEOUT cycles after
  // the xfer_i cycle. RELEASE is excluded so the pulse fires only once.
  vme_dly_cnt #(.W(c_TW)) u_tmo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (state == IDLE),
    .load_val_i (c_TW'(g_TIMEOUT - 2)),
    .zero_o     (tmo_zero)
  );

  assign tmo_fire = tmo_zero && (state != IDLE) && (state != RELEASE);
`else
  assign tmo_fire = 1'b0;
`endif

  // ------------------------------------------------------------ next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (xfer_i) state_nx = WAIT_RDY;
      WAIT_RDY: begin
        if (abort)          state_nx = RELEASE;
        else if (rdy_i) begin
          if (err_i)        state_nx = ERR;
          else if (is_read_q) state_nx = TURN_OFF;
          else              state_nx = ACK;
        end
      end
      TURN_OFF: if (abort) state_nx = RELEASE; else if (dly_zero) state_nx = TURN_ON;
      TURN_ON:  if (abort) state_nx = RELEASE; else if (dly_zero) state_nx = DRIVE;
      DRIVE:    if (abort) state_nx = RELEASE; else if (dly_zero) state_nx = ACK;
      ACK, ERR: if (ds_n_i == 2'b11) state_nx = RELEASE;
      RELEASE:  if (dly_zero) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (tmo_fire) state_nx = RELEASE;
  end

  // -------------------------------------------- output values for next cycle
  assign first_rel = (state_nx == RELEASE) && (state != RELEASE);

  always_comb begin
    drive_nx     = 1'b0;
    sample_nx    = 1'b0;
    done_nx      = 1'b0;
    addr_oe_n_nx = 1'b0;
    dir_nx       = c_DIR_BUS2FPGA;
    oe_n_nx      = 1'b0;
    dtack_oe_nx  = 1'b0;
    dtack_n_nx   = 1'b1;
    berr_nx      = 1'b0;
    case (state_nx)
      IDLE:     done_nx = (state == RELEASE);
      TURN_OFF: oe_n_nx = 1'b1;
      TURN_ON: begin
        oe_n_nx  = 1'b1;
        dir_nx   = c_DIR_FPGA2BUS;
        drive_nx = 1'b1;
      end
      DRIVE: begin
        dir_nx   = c_DIR_FPGA2BUS;
        drive_nx = 1'b1;
      end
      ACK: begin
        dtack_oe_nx = 1'b1;
        dtack_n_nx  = 1'b0;
        sample_nx   = (state == WAIT_RDY);
        if (is_read_q) begin
          dir_nx   = c_DIR_FPGA2BUS;
          drive_nx = 1'b1;
        end
      end
      ERR:      berr_nx = 1'b1;
      RELEASE: begin
        oe_n_nx     = 1'b1;
        // Direction holds for the first RELEASE cycle while the FPGA driver
        // turns off, then flips back with OE still disabled.
        dir_nx      = first_rel ? data_dir_o : c_DIR_BUS2FPGA;
        // Only an acknowledged cycle actively drives DTACK high briefly.
        dtack_oe_nx = first_rel && (state == ACK);
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      is_read_q     <= 1'b0;
      data_drive_o  <= 1'b0;
      data_sample_o <= 1'b0;
      done_o        <= 1'b0;
      addr_dir_o    <= c_DIR_BUS2FPGA;
      addr_oe_n_o   <= 1'b1;
      data_dir_o    <= c_DIR_BUS2FPGA;
      data_oe_n_o   <= 1'b1;
      dtack_oe_o    <= 1'b0;
      dtack_n_o     <= 1'b1;
      berr_o        <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      state         <= state_nx;
      if ((state == IDLE) && xfer_i) is_read_q <= is_read_i;
      data_drive_o  <= drive_nx;
      data_sample_o <= sample_nx;
      done_o        <= done_nx;
      addr_dir_o    <= c_DIR_BUS2FPGA;
      addr_oe_n_o   <= addr_oe_n_nx;
      data_dir_o    <= dir_nx;
      data_oe_n_o   <= oe_n_nx;
      dtack_oe_o    <= dtack_oe_nx;
      dtack_n_o     <= dtack_n_nx;
      berr_o        <= berr_nx;
      timeout_o     <= tmo_fire;
    end
  end

endmodule

// File: tb/tb_vme_buf_ctrl.sv
// tb/tb_vme_buf_ctrl.sv - directed self-checking bench for vme_buf_ctrl

module tb_vme_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       as_n = 1'b1;
  logic [1:0] ds_n = 2'b11;
  logic       xfer = 1'b0, is_read = 1'b0, rdy = 1'b0, err = 1'b0;
  logic       data_drive_o, data_sample_o, done_o, addr_dir_o, addr_oe_n_o;
  logic       data_dir_o, data_oe_n_o, dtack_oe_o, dtack_n_o, berr_o, timeout_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic prev_dir = 1'b0;

  vme_buf_ctrl #(.g_DEAD(2), .g_SETTLE(3), .g_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .as_n_i(as_n), .ds_n_i(ds_n),
    .xfer_i(xfer), .is_read_i(is_read), .rdy_i(rdy), .err_i(err),
    .data_drive_o(data_drive_o), .data_sample_o(data_sample_o), .done_o(done_o),
    .addr_dir_o(addr_dir_o), .addr_oe_n_o(addr_oe_n_o),
    .data_dir_o(data_dir_o), .data_oe_n_o(data_oe_n_o),
    .dtack_oe_o(dtack_oe_o), .dtack_n_o(dtack_n_o), .berr_o(berr_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rd);
    as_n = 1'b0; ds_n = 2'b00; xfer = 1'b1; is_read = rd;
    tick();
    xfer = 1'b0;
  endtask

  task automatic bus_release();
    as_n = 1'b1; ds_n = 2'b11;
  endtask

  // Invariants checked every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      n_assert++;
      assert (!(data_drive_o === 1'b1 && data_dir_o !== 1'b1)) else begin
        n_fail++;
        $error("FAIL inv_drive_dir: drive=%b dir=%b required dir=1", data_drive_o, data_dir_o);
      end
      if (data_dir_o !== prev_dir) begin
        n_assert++;
        assert (data_oe_n_o === 1'b1) else begin
          n_fail++;
          $error("FAIL inv_oe_on_flip: oe_n=%b required 1", data_oe_n_o);
        end
      end
    end
    prev_dir = data_dir_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst_addr_oe_n", addr_oe_n_o, 1'b1);
    chk("rst_data_oe_n", data_oe_n_o, 1'b1);
    chk("rst_dtack_n",   dtack_n_o,   1'b1);
    chk("rst_dtack_oe",  dtack_oe_o,  1'b0);
    chk("rst_berr",      berr_o,      1'b0);
    chk("rst_timeout",   timeout_o,   1'b0);
    rst = 1'b0;
    tick();
    chk("idle_addr_oe_n", addr_oe_n_o, 1'b0);
    chk("idle_data_oe_n", data_oe_n_o, 1'b0);
    chk("idle_data_dir",  data_dir_o,  1'b0);
    chk("idle_addr_dir",  addr_dir_o,  1'b0);
    chk("idle_dtack_n",   dtack_n_o,   1'b1);

    // Read: rdy at cycle 0
    start(1'b1);
    chk("rd_wait_oe_n", data_oe_n_o, 1'b0);
    rdy = 1'b1;
    tick(); rdy = 1'b0;                               // cycle 1
    chk("rd_c1_oe_n", data_oe_n_o, 1'b1);
    chk("rd_c1_dir",  data_dir_o,  1'b0);
    tick(); tick();                                   // cycle 3
    chk("rd_c3_dir",   data_dir_o,   1'b1);
    chk("rd_c3_drive", data_drive_o, 1'b1);
    chk("rd_c3_oe_n",  data_oe_n_o,  1'b1);
    tick();
    chk("rd_c4_oe_n", data_oe_n_o, 1'b1);
    tick();                                           // cycle 5
    chk("rd_c5_oe_n", data_oe_n_o, 1'b0);
    tick(); tick();                                   // cycle 7
    chk("rd_c7_dtack_n", dtack_n_o, 1'b1);
    tick();                                           // cycle 8
    chk("rd_c8_dtack_n",  dtack_n_o,  1'b0);
    chk("rd_c8_dtack_oe", dtack_oe_o, 1'b1);
    tick();
    chk("rd_hold_dtack_n", dtack_n_o, 1'b0);
    bus_release();
    tick();                                           // RELEASE 1
    chk("rd_r1_dtack_n",  dtack_n_o,    1'b1);
    chk("rd_r1_dtack_oe", dtack_oe_o,   1'b1);
    chk("rd_r1_drive",    data_drive_o, 1'b0);
    chk("rd_r1_dir",      data_dir_o,   1'b1);
    chk("rd_r1_oe_n",     data_oe_n_o,  1'b1);
    tick();                                           // RELEASE 2
    chk("rd_r2_dtack_oe", dtack_oe_o,  1'b0);
    chk("rd_r2_dir",      data_dir_o,  1'b0);
    chk("rd_r2_oe_n",     data_oe_n_o, 1'b1);
    tick();
    chk("rd_done",      done_o,      1'b1);
    chk("rd_idle_oe_n", data_oe_n_o, 1'b0);
    tick();
    chk("rd_done_pulse", done_o, 1'b0);

    // Write
    start(1'b0);
    rdy = 1'b1;
    tick(); rdy = 1'b0;                               // cycle 1
    chk("wr_c1_sample",  data_sample_o, 1'b1);
    chk("wr_c1_dtack_n", dtack_n_o,     1'b0);
    chk("wr_c1_dir",     data_dir_o,    1'b0);
    chk("wr_c1_drive",   data_drive_o,  1'b0);
    tick();
    chk("wr_c2_sample",  data_sample_o, 1'b0);
    chk("wr_c2_dtack_n", dtack_n_o,     1'b0);
    bus_release();
    tick();
    chk("wr_r1_dtack_n",  dtack_n_o,   1'b1);
    chk("wr_r1_dtack_oe", dtack_oe_o,  1'b1);
    chk("wr_r1_oe_n",     data_oe_n_o, 1'b1);
    chk("wr_r1_dir",      data_dir_o,  1'b0);
    tick();
    chk("wr_r2_dtack_oe", dtack_oe_o, 1'b0);
    tick();
    chk("wr_done", done_o, 1'b1);

    // Error
    start(1'b1);
    rdy = 1'b1; err = 1'b1;
    tick(); rdy = 1'b0; err = 1'b0;
    chk("err_berr",     berr_o,     1'b1);
    chk("err_dtack_oe", dtack_oe_o, 1'b0);
    chk("err_dtack_n",  dtack_n_o,  1'b1);
    chk("err_dir",      data_dir_o, 1'b0);
    tick();
    chk("err_hold_berr", berr_o, 1'b1);
    bus_release();
    tick();
    chk("err_r1_berr",     berr_o,     1'b0);
    chk("err_r1_dtack_oe", dtack_oe_o, 1'b0);
    tick(); tick();
    chk("err_done", done_o, 1'b1);

    // Abort during DRIVE
    start(1'b1);
    rdy = 1'b1;
    tick(); rdy = 1'b0;                               // cycle 1
    tick(); tick(); tick(); tick();                   // cycle 5, DRIVE
    chk("ab_c5_oe_n", data_oe_n_o, 1'b0);
    bus_release();
    tick();                                           // RELEASE 1
    chk("ab_r1_oe_n",     data_oe_n_o,  1'b1);
    chk("ab_r1_drive",    data_drive_o, 1'b0);
    chk("ab_r1_dir",      data_dir_o,   1'b1);
    chk("ab_r1_dtack_oe", dtack_oe_o,   1'b0);
    chk("ab_r1_dtack_n",  dtack_n_o,    1'b1);
    tick();
    chk("ab_r2_dir",     data_dir_o, 1'b0);
    chk("ab_r2_dtack_n", dtack_n_o,  1'b1);
    tick();
    chk("ab_done",      done_o,      1'b1);
    chk("ab_idle_oe_n", data_oe_n_o, 1'b0);

    // Abort beats rdy in the same cycle
    start(1'b0);
    rdy = 1'b1; bus_release();
    tick(); rdy = 1'b0;
    chk("abr_sample",   data_sample_o, 1'b0);
    chk("abr_dtack_n",  dtack_n_o,     1'b1);
    chk("abr_dtack_oe", dtack_oe_o,    1'b0);
    chk("abr_oe_n",     data_oe_n_o,   1'b1);
    tick(); tick();
    chk("abr_done", done_o, 1'b1);

    // Reset mid-transfer
    start(1'b1);
    rdy = 1'b1;
    tick(); rdy = 1'b0;
    tick(); tick(); tick(); tick();                   // DRIVE
    rst = 1'b1;
    tick();
    chk("mrst_data_oe_n", data_oe_n_o,  1'b1);
    chk("mrst_addr_oe_n", addr_oe_n_o,  1'b1);
    chk("mrst_dir",       data_dir_o,   1'b0);
    chk("mrst_drive",     data_drive_o, 1'b0);
    bus_release();
    rst = 1'b0;
    tick();
    chk("mrst_idle_oe_n", data_oe_n_o, 1'b0);

`ifdef VME_BUF_TIMEOUT_EN
    // Watchdog, g_TIMEOUT = 16: xfer at cycle 0, pulse at cycle 16
    start(1'b1);                                      // cycle 1
    repeat (14) tick();                               // cycle 15
    chk("tmo_c15", timeout_o, 1'b0);
    tick();
    chk("tmo_c16", timeout_o, 1'b1);
    tick();
    chk("tmo_c17", timeout_o, 1'b0);
    tick();
    chk("tmo_done", done_o, 1'b1);
    bus_release();
    tick();
`else
    chk("no_tmo", timeout_o, 1'b0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vme_buf_ctrl.md
Name: vme_buf_ctrl

Overview:
- FPGA-side sequencer that drives the direction and output-enable pins of the VME address, data and DTACK transceivers.
- Also drives DTACK/BERR toward those transceivers.
- Sits directly upstream of the board buffer stage (SN74VMEH22501 plus bidirectional buffers): the VME slave core requests a transfer, and this block reverses the data path with dead time, acknowledges, then restores bus-to-FPGA listening.
- Prevents bus contention during read turnaround.

Parameters:
- g_DEAD, 2, cycles with data OE disabled before and after a DIR change (>=1)
- g_SETTLE, 3, cycles data is driven before DTACK asserts on reads (>=1)
- g_TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- as_n_i  in  1  VME AS_n, already synchronised to clk_i
- ds_n_i  in  2  VME DS_n[1:0], already synchronised
- xfer_i  in  1  one-cycle pulse from decoder: address matched and DS asserted
- is_read_i  in  1  sampled with xfer_i; 1 = slave drives data
- rdy_i  in  1  core pulse: read data valid / write accepted
- err_i  in  1  sampled with rdy_i; 1 = terminate with BERR
- data_drive_o  out  1  enables the FPGA-side data tri-state
- data_sample_o  out  1  one-cycle pulse: latch write data
- done_o  out  1  one-cycle pulse when returning to IDLE
- addr_dir_o  out  1  VME_ADDR_DIR (0 = bus->FPGA)
- addr_oe_n_o  out  1  VME_ADDR_OE_N
- data_dir_o  out  1  VME_DATA_DIR (0 = bus->FPGA, 1 = FPGA->bus)
- data_oe_n_o  out  1  VME_DATA_OE_N
- dtack_oe_o  out  1  VME_DTACK_OE
- dtack_n_o  out  1  VME_DTACK_n
- berr_o  out  1  VME_BERR (active high toward the buffer)
- timeout_o  out  1  watchdog pulse (tied 0 without the feature)

Behaviour:
- All outputs are registered.
- Reset values:
  - addr_oe_n_o = 1, data_oe_n_o = 1, addr_dir_o = 0, data_dir_o = 0
  - dtack_oe_o = 0, dtack_n_o = 1, berr_o = 0
  - data_drive_o = 0, data_sample_o = 0, done_o = 0, timeout_o = 0
- IDLE:
  - addr_oe_n_o = 0, data_oe_n_o = 0, both DIR = 0.
  - Entered on the first cycle after reset deasserts, so OEs go low one cycle after reset release.
- addr_dir_o stays 0 permanently (D32 slave only; multiplexed A64 is out of scope).
- IDLE: on xfer_i, latch is_read_i -> WAIT_RDY. xfer_i in any other state is ignored.
- WAIT_RDY: on rdy_i, latch err_i.
  - Error -> ERR.
  - Write -> ACK, with data_sample_o high for one cycle on ACK entry.
  - Read -> TURN_OFF.
- TURN_OFF: data_oe_n_o = 1 for g_DEAD cycles -> TURN_ON.
- TURN_ON: data_dir_o = 1, data_drive_o = 1, OE still off, g_DEAD cycles -> DRIVE.
- DRIVE: data_oe_n_o = 0 for g_SETTLE cycles -> ACK.
- Read latency: dtack_n_o falls at rdy_i cycle + 1 + 2*g_DEAD + g_SETTLE.
- ACK: dtack_oe_o = 1, dtack_n_o = 0; hold until ds_n_i == 2'b11 -> RELEASE.
- ERR: berr_o = 1, dtack_oe_o = 0; hold until ds_n_i == 2'b11 -> RELEASE.
- RELEASE, for g_DEAD cycles:
  - dtack_n_o = 1 with dtack_oe_o = 1 (actively drives DTACK high), then dtack_oe_o = 0.
  - berr_o = 0, data_oe_n_o = 1, data_drive_o = 0.
  - data_dir_o = 0 only after data_drive_o has been 0 for >=1 cycle.
  - Then -> IDLE with done_o pulse; data_oe_n_o = 0 on IDLE entry.
- Write path never changes data_dir_o; RELEASE still applies dead time to OE.
- Abort: in WAIT_RDY/TURN_OFF/TURN_ON/DRIVE, if as_n_i = 1 and ds_n_i = 2'b11 -> RELEASE without DTACK/BERR.
  - rdy_i arriving the same cycle loses to abort.
- Invariant: data_oe_n_o = 0 is never asserted in the cycle data_dir_o changes.
- Invariant: data_drive_o = 1 implies data_dir_o = 1.
- rst_i mid-transfer: all outputs return to reset values next edge; the bus is released immediately.

Optional Feature:
- Macro: VME_BUF_TIMEOUT_EN
- With the macro:
  - A counter runs in every non-IDLE state and clears on state change to IDLE.
  - Reaching g_TIMEOUT forces RELEASE and pulses timeout_o for one cycle.
- Without the macro: no counter, timeout_o tied 0; the FSM can wait indefinitely.

Decomposition:
- Package vme_buf_ctrl_pkg:
  - state enum t_buf_state (IDLE, WAIT_RDY, TURN_OFF, TURN_ON, DRIVE, ACK, ERR, RELEASE)
  - constants c_DIR_BUS2FPGA = 0, c_DIR_FPGA2BUS = 1
- One sub-module, vme_dly_cnt: loadable down-counter with load/zero flag, shared by the dead-time, settle and timeout delays.

Test Plan:
- Reset release: rst_i 1->0 -> all OEs high during reset, addr_oe_n_o/data_oe_n_o = 0 one cycle later, dtack_n_o = 1.
- Read, g_DEAD = 2, g_SETTLE = 3, rdy_i at cycle 0:
  - data_oe_n_o = 1 at cycle 1
  - data_dir_o = 1 at cycle 3
  - data_oe_n_o = 0 at cycle 5
  - dtack_n_o = 0 at cycle 8
  - DS release -> DIR back to 0 with OE high throughout the flip.
- Write: xfer_i, is_read_i = 0, rdy_i at cycle 0 -> data_sample_o and dtack_n_o = 0 at cycle 1, data_dir_o stays 0 throughout; DS release -> done_o.
- Error: rdy_i with err_i = 1 -> berr_o = 1, dtack_oe_o = 0 until ds_n_i = 11, then berr_o = 0, done_o.
- Abort: master raises AS and DS during DRIVE -> RELEASE, no DTACK edge, IDLE after g_DEAD cycles; assertion checker confirms both invariants.
- VME_BUF_TIMEOUT_EN, g_TIMEOUT = 16: rdy_i never arrives -> timeout_o pulse at cycle 16 after xfer_i, FSM returns to IDLE.
